pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Control FSM for the 8-bit PC unit of the calculator. Drives its mode select
//  m[1:0] (00 inc, 01 dec, 10 load switches, 11 load ALU result) and its step
//  counter, which must read zero for the PC to count. Adds free-run,
//  single-step, load/jump request handshakes and a PC breakpoint.
//  Sits between the board switches/buttons and the PC unit.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per automatic PC step in RUN (>=1)
//  PC_W      8           PC width, equal to the PC unit and data switches
// PORTS
//  clk       in   1     system clock; all state updates on posedge
//  clr       in   1     reset, asynchronous, active-low
//  run       in   1     level: 1 = free-run stepping, 0 = stop
//  dir       in   1     0 = count up (m=00), 1 = count down (m=01)
//  step      in   1     single-step request, rising-edge detected
//  load_req  in   1     load PC from switches, rising-edge detected
//  jump_req  in   1     load PC from ALU result, rising-edge detected
//  brk_en    in   1     breakpoint enable
//  brk_addr  in   PC_W  breakpoint PC value
//  pc_in     in   PC_W  current PC fed back from the PC unit
//  m         out  2     mode select to the PC unit
//  step_cnt  out  32    step counter to the PC unit; 0 = count this cycle
//  ack       out  1     1-cycle pulse in the cycle the load/jump mode is driven
//  halted    out  1     1 while in HALT
//  busy      out  1     1 in RUN, LOAD or JUMP
// BEHAVIOUR
//  - All outputs registered. The PC unit samples on the following negedge.
//  - Reset (clr=0, async): state=IDLE, m=00, step_cnt=1, ack=0, halted=0,
//    busy=0, prescaler=TICK_DIV-1, edge registers=0.
//  - States: IDLE, RUN, LOAD, JUMP, HALT. step_cnt!=0 means PC holds.
//  - Request events: load_ev, jump_ev and step_ev are rising edges (input high
//    now, registered copy low). A level held high is served once.
//  - Priority when events coincide: load_ev > jump_ev > step_ev > run.
//    A lower-priority event that loses is dropped, not queued.
//  - IDLE: m={0,dir}, step_cnt=1.
//    load_ev->LOAD; jump_ev->JUMP;
//    step_ev: one cycle with step_cnt=0, m={0,dir}, stay IDLE;
//    run=1: go to RUN, prescaler=TICK_DIV-1.
//  - RUN: m={0,dir}, step_cnt=prescaler. Prescaler decrements each cycle and
//    reloads TICK_DIV-1 after 0, so there is one zero every TICK_DIV cycles.
//    run=0: go to IDLE, step_cnt=1.
//    step_ev is ignored in RUN.
//  - Breakpoint: in RUN, if brk_en and pc_in==brk_addr on a cycle where the
//    prescaler would emit 0, emit step_cnt=1 instead and go to HALT.
//  - LOAD: one cycle, m=10, step_cnt=1, ack=1; then return to the originating
//    state (IDLE or RUN). The prescaler is frozen for that cycle.
//  - JUMP: same as LOAD but m=11.
//  - HALT: m=00, step_cnt=1, halted=1.
//    load_ev/jump_ev are served and return to HALT.
//    run=0 goes to IDLE, clearing halted. Stepping never resumes while run=1.
//  - A dir change applies from the next registered cycle. No glitch on m.
//  - TICK_DIV=1: step_cnt=0 every RUN cycle.
//  - clr low mid-operation aborts any LOAD/JUMP. No ack is issued.
// TESTING (TICK_DIV=4)
//  - Reset: clr=0 -> m=00, step_cnt=1, ack=0, busy=0, halted=0, held async.
//  - run=1,dir=0 for 12 cycles -> step_cnt=3,2,1,0 repeating; 3 zero cycles.
//    PC unit advances 0->3.
//  - IDLE: step pulse held 5 cycles -> exactly one step_cnt=0 cycle.
//    With dir=1, PC goes 0x00->0xFF.
//  - load_req and jump_req rise in the same cycle -> one cycle m=10, ack=1.
//    jump is dropped. PC equals the switch value, e.g. 0x5A.
//  - RUN, brk_en=1, brk_addr=0x02 from PC=0 -> PC stops at 0x02, halted=1.
//    run=0 -> IDLE, halted=0.
//  - RUN with jump_req at prescaler=2 -> m=11 for 1 cycle, ack=1.
//    Prescaler resumes at 2. Then clr=0 -> outputs reset immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its environment (switches/buttons and PC unit).
//  run, dir, step, load_req, jump_req, brk_en, brk_addr, pc_in : requests / feedback into the sequencer
//  m, step_cnt, ack, halted, busy                                : control/status out of the sequencer
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            run;
  logic            dir;
  logic            step;
  logic            load_req;
  logic            jump_req;
  logic            brk_en;
  logic [PC_W-1:0] brk_addr;
  logic [PC_W-1:0] pc_in;
  logic [1:0]      m;
  logic [31:0]     step_cnt;
  logic            ack;
  logic            halted;
  logic            busy;

  // Environment side: issues requests, observes control/status.
  modport master (
    output run, dir, step, load_req, jump_req, brk_en, brk_addr, pc_in,
    input  m, step_cnt, ack, halted, busy
  );

  // Sequencer side.
  modport slave (
    input  run, dir, step, load_req, jump_req, brk_en, brk_addr, pc_in,
    output m, step_cnt, ack, halted, busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// Control FSM for the 8-bit PC unit: drives the PC mode select and step counter,
// with free-run stepping, single-step, load/jump request handshakes and a PC
// breakpoint. All outputs are registered; the PC unit samples them on negedge.
//  clk    : system clock, posedge
//  clr    : asynchronous active-low reset
//  bus    : pc_sequencer_if slave (requests in, m/step_cnt/ack/halted/busy out)
module pc_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PC_W     = 8
) (
  input  logic           clk,
  input  logic           clr,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_LOAD = 3'd2,
    S_JUMP = 3'd3,
    S_HALT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             step_q, load_q, jump_q;

  logic [1:0]       m_q, m_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             ack_q, ack_d;
  logic             halted_q, halted_d;
  logic             busy_q, busy_d;

  logic             step_ev, load_ev, jump_ev;
  logic             step_pulse;
  logic             emit_en;
  logic [CNT_W-1:0] emit_v;
  logic             bp_match;

  // Rising-edge request detection; a held level is served once.
  assign step_ev  = bus.step     & ~step_q;
  assign load_ev  = bus.load_req & ~load_q;
  assign jump_ev  = bus.jump_req & ~jump_q;
  assign bp_match = (PC_W'(bus.pc_in) == PC_W'(bus.brk_addr));

  // State register, return state, prescaler and edge registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      presc_q <= PRESC_MAX;
      step_q  <= 1'b0;
      load_q  <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      presc_q <= presc_d;
      step_q  <= bus.step;
      load_q  <= bus.load_req;
      jump_q  <= bus.jump_req;
    end
  end

  // Next state. Priority: load > jump > step > run; losers are dropped.
  // emit_en marks a RUN cycle whose step_cnt comes from the prescaler.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    presc_d    = presc_q;
    step_pulse = 1'b0;
    emit_en    = 1'b0;
    emit_v     = presc_q;
    case (state_q)
      S_IDLE: begin
        if (load_ev) begin
          state_d = S_LOAD;
          ret_d   = S_IDLE;
        end else if (jump_ev) begin
          state_d = S_JUMP;
          ret_d   = S_IDLE;
        end else if (step_ev) begin
          step_pulse = 1'b1;
        end else if (bus.run) begin
          state_d = S_RUN;
          emit_en = 1'b1;
          emit_v  = PRESC_MAX;
        end
      end
      S_RUN: begin
        // Prescaler stays frozen on the edge into LOAD/JUMP.
        if (load_ev) begin
          state_d = S_LOAD;
          ret_d   = S_RUN;
        end else if (jump_ev) begin
          state_d = S_JUMP;
          ret_d   = S_RUN;
        end else if (!bus.run) begin
          state_d = S_IDLE;
        end else begin
          emit_en = 1'b1;
        end
      end
      S_LOAD, S_JUMP: begin
        state_d = ret_q;
        emit_en = (ret_q == S_RUN);
      end
      S_HALT: begin
        if (load_ev) begin
          state_d = S_LOAD;
          ret_d   = S_HALT;
        end else if (jump_ev) begin
          state_d = S_JUMP;
          ret_d   = S_HALT;
        end else if (!bus.run) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit_en) begin
      presc_d = (emit_v == '0) ? PRESC_MAX : emit_v - CNT_W'(1);
      // Breakpoint swallows the step the prescaler would have issued.
      if ((emit_v == '0) && bus.brk_en && bp_match) begin
        state_d = S_HALT;
      end
    end
  end

  // Output decode from the next state, registered below.
  always_comb begin
    m_d        = {1'b0, bus.dir};
    step_cnt_d = CNT_W'(1);
    ack_d      = 1'b0;
    halted_d   = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      S_IDLE: begin
        if (step_pulse) step_cnt_d = '0;
      end
      S_RUN: begin
        step_cnt_d = emit_v;
        busy_d     = 1'b1;
      end
      S_LOAD: begin
        m_d    = 2'b10;
        ack_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_JUMP: begin
        m_d    = 2'b11;
        ack_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_HALT: begin
        m_d      = 2'b00;
        halted_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_q        <= 2'b00;
      step_cnt_q <= CNT_W'(1);
      ack_q      <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      m_q        <= m_d;
      step_cnt_q <= step_cnt_d;
      ack_q      <= ack_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.m        = m_q;
  assign bus.step_cnt = step_cnt_q;
  assign bus.ack      = ack_q;
  assign bus.halted   = halted_q;
  assign bus.busy     = busy_q;

endmodule
